memory_stage_hs: RTL
====================

// Module: memory_stage_hs
// PURPOSE
//  Parametrised MEM pipeline stage. Latches the execute-stage bundle, resolves branch
//  redirect, and runs loads/stores over a valid/ready data-memory bus with
//  byte/half/word(/dword) lanes and sign/zero extension. Stalls upstream via in_ready.
//  Presents a valid/ready result bundle to writeback. Sits between execute and writeback.
// PARAMETERS
//  DATA_W     32  datapath width; 32 or 64 only; strobe width DATA_W/8
//  ADDR_W     32  data-memory address width
//  REG_IDX_W  5   destination register index width
// PORTS
//  clk            in   1          clock
//  reset          in   1          asynchronous, active-high reset
//  flush          in   1          kill the op currently held in the stage
//  in_valid       in   1          execute bundle valid
//  in_ready       out  1          stage can accept the bundle this cycle
//  in_alu_result  in   DATA_W     ALU result; memory address for loads/stores
//  in_write_data  in   DATA_W     store data, right-aligned
//  in_write_reg   in   REG_IDX_W  destination register
//  in_reg_write   in   1          op writes the register file
//  in_mem_to_reg  in   1          op is a load
//  in_mem_write   in   1          op is a store
//  in_mem_size    in   2          0 byte, 1 half, 2 word, 3 dword (3 is treated as 2 when DATA_W=32)
//  in_mem_unsigned in  1          load zero-extends (else sign-extends)
//  in_branch      in   1          op is a conditional branch
//  in_zero        in   1          ALU zero flag
//  pcsrc          out  1          branch-taken redirect pulse
//  dreq_valid     out  1          bus request valid
//  dreq_ready     in   1          bus accepts request
//  dreq_addr      out  ADDR_W     request address, low log2(DATA_W/8) bits cleared
//  dreq_wen       out  1          1 store, 0 load
//  dreq_strb      out  DATA_W/8   byte-lane enables
//  dreq_wdata     out  DATA_W     store data replicated into the addressed lanes
//  dresp_valid    in   1          response (load data or store ack), one cycle
//  dresp_rdata    in   DATA_W     load data, full bus word
//  out_valid      out  1          writeback bundle valid
//  out_ready      in   1          writeback accepts the bundle
//  out_alu_result out  DATA_W     forwarded ALU result
//  out_read_data  out  DATA_W     extended load data (0 for non-loads)
//  out_write_reg  out  REG_IDX_W  destination register
//  out_reg_write  out  1          register-file write enable
//  out_mem_to_reg out  1          select load data
//  out_misalign   out  1          misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE. All outputs are 0, except in_ready=1.
//  - FSM states: IDLE (empty), REQ (dreq_valid=1), WAIT (awaiting dresp), DONE (out_valid=1).
//  - in_ready = (IDLE) | (DONE & out_ready). A capture occurs on in_valid & in_ready & !flush.
//  - Capture of a non-memory op goes to DONE the next cycle (1-cycle latency).
//  - Capture of a load or store goes to REQ.
//  - REQ goes to WAIT on dreq_valid & dreq_ready. Request fields are held stable while in REQ.
//  - WAIT goes to DONE on dresp_valid. dresp_valid is ignored outside WAIT.
//  - The bus guarantees at least 1 cycle between request acceptance and response.
//  - Load data is registered in the same cycle as dresp_valid.
//  - DONE goes to IDLE on out_ready without a new capture, or reloads on back-to-back capture.
//  - Lanes: off = addr[log2(DATA_W/8)-1:0].
//    byte strb = 1<<off; half strb = 2'b11<<off; word strb = 4'hF<<off; dword strb = all ones.
//  - Load result: extract the addressed lanes, then zero- or sign-extend to DATA_W.
//  - pcsrc is 1 for exactly one cycle, the first cycle after capture, when branch & zero.
//    It is not re-asserted while the op stalls in the stage.
//  - Flush in IDLE or DONE: the stage is empty next cycle (out_valid=0).
//  - Flush in REQ or WAIT: the op is marked killed and the bus handshake completes.
//    A killed op then goes to IDLE with no out_valid. in_ready stays 0 until IDLE.
//  - Flush together with in_valid: no capture occurs; flush wins.
//  - Reset mid-transaction: the FSM returns to IDLE immediately. The bus tolerates the abandoned request.
// CONFIGURATION
//  - MEM_ALIGN_CHECK_EN defined:
//    misaligned means half with off[0]!=0, word with off[1:0]!=0, or dword with off[2:0]!=0.
//    A misaligned load or store is not issued to the bus.
//    It goes to DONE in 1 cycle with out_misalign=1, out_reg_write=0, out_read_data=0.
//  - MEM_ALIGN_CHECK_EN undefined: no check is made and out_misalign is tied to 0.
//    off is forced to size alignment (half off[0]=0, word off[1:0]=0, dword off=0) before lane select.
// TESTING
//  - ALU op, alu_result=32'h1234, reg 5, out_ready=1 -> out_valid next cycle, out_alu_result=32'h1234, no dreq.
//  - lb addr=0x1003, dresp_rdata=32'h80FF_FF00 -> strb 4'b1000, out_read_data=32'hFFFF_FF80.
//    Repeat with unsigned -> 32'h0000_0080.
//  - sh addr=0x2002, data=32'h0000_ABCD, dreq_ready low 3 cycles -> strb 4'b1100,
//    wdata=32'hABCD_ABCD, request held stable, in_ready=0 until DONE.
//  - branch zero=1, out_ready low 4 cycles -> pcsrc high exactly 1 cycle.
//  - flush in WAIT for load -> dresp consumed, no out_valid, in_ready returns to 1.
//  - MEM_ALIGN_CHECK_EN: lw addr=0x3002 -> no dreq_valid, out_misalign=1, out_reg_write=0.
//    DATA_W=64 ld addr=0x8 -> strb 8'hFF.

Source files
------------

// File: rtl/memory_stage_hs.sv
// -----------------------------------------------------------------------------
// memory_stage_hs
//   MEM pipeline stage sitting between execute and writeback. Latches the
//   execute bundle, raises a one-cycle branch redirect, runs loads/stores over
//   a valid/ready data-memory bus with byte/half/word(/dword) lanes and
//   sign/zero extension, and hands a valid/ready bundle to writeback.
//
//   Optional feature macro: MEM_ALIGN_CHECK_EN
//     defined   : misaligned loads/stores skip the bus and complete in one
//                 cycle with out_misalign=1, out_reg_write=0, out_read_data=0.
//     undefined : no check; the lane offset is forced to size alignment and
//                 out_misalign is tied to 0.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   flush               kill the op currently held in the stage
//   in_valid/in_ready   execute-side handshake
//   in_*                execute bundle (alu result/address, store data, dest
//                       reg, reg write, load, store, size, unsigned, branch, zero)
//   pcsrc               branch-taken redirect pulse
//   dreq_*              data-memory request (valid/ready, addr, wen, strb, wdata)
//   dresp_valid/rdata   data-memory response (one cycle)
//   out_valid/out_ready writeback-side handshake
//   out_*               writeback bundle and misalignment flag
// -----------------------------------------------------------------------------
module memory_stage_hs #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int REG_IDX_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_write_data,
   input  logic [REG_IDX_W-1:0]  in_write_reg,
   input  logic                  in_reg_write,
   input  logic                  in_mem_to_reg,
   input  logic                  in_mem_write,
   input  logic [1:0]            in_mem_size,
   input  logic                  in_mem_unsigned,
   input  logic                  in_branch,
   input  logic                  in_zero,
   output logic                  pcsrc,
   output logic                  dreq_valid,
   input  logic                  dreq_ready,
   output logic [ADDR_W-1:0]     dreq_addr,
   output logic                  dreq_wen,
   output logic [DATA_W/8-1:0]   dreq_strb,
   output logic [DATA_W-1:0]     dreq_wdata,
   input  logic                  dresp_valid,
   input  logic [DATA_W-1:0]     dresp_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_alu_result,
   output logic [DATA_W-1:0]     out_read_data,
   output logic [REG_IDX_W-1:0]  out_write_reg,
   output logic                  out_reg_write,
   output logic                  out_mem_to_reg,
   output logic                  out_misalign
);

   // state | meaning
   // IDLE  | stage empty, accepts a bundle
   // REQ   | memory request presented (dreq_valid=1), fields frozen
   // WAIT  | request accepted, waiting for dresp_valid
   // DONE  | result presented to writeback (out_valid=1)
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = (DATA_W == 64) ? 3 : 2;

   logic [1:0]           state_q;
   logic [DATA_W-1:0]    alu_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [REG_IDX_W-1:0] wreg_q;
   logic                 reg_write_q;
   logic                 mem_to_reg_q;
   logic                 mem_write_q;
   logic [1:0]           size_q;
   logic                 unsigned_q;
   logic                 killed_q;
   logic [DATA_W-1:0]    rdata_q;
   logic                 pcsrc_q;

   logic                 capture;
   logic                 mis_in;
   logic                 is_mem_in;
   logic [1:0]           size_in;
   logic                 in_req;

   logic [ADDR_W-1:0]    addr_full;
   logic [OFF_W-1:0]     off_al;
   logic [STRB_W-1:0]    strb_c;
   logic [DATA_W-1:0]    wd_rep;
   logic [DATA_W-1:0]    shifted;
   logic [DATA_W-1:0]    mask;
   logic                 sgn;
   logic [DATA_W-1:0]    ld_ext;

   // A 32-bit datapath has no dword lanes; dword requests degrade to word.
   assign size_in = (DATA_W == 32 && in_mem_size == SZ_D) ? SZ_W : in_mem_size;

`ifdef MEM_ALIGN_CHECK_EN
   logic [OFF_W-1:0] off_in;
   logic             mis_raw;

   assign off_in = in_alu_result[OFF_W-1:0];

   always_comb begin
      mis_raw = 1'b0;
      case (size_in)
         SZ_H:    mis_raw = off_in[0];
         SZ_W:    mis_raw = |off_in[1:0];
         SZ_D:    mis_raw = |off_in;
         default: mis_raw = 1'b0;
      endcase
   end

   assign mis_in = mis_raw & (in_mem_to_reg | in_mem_write);
`else
   assign mis_in = 1'b0;
`endif

   assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign capture   = in_valid & in_ready & ~flush;
   assign is_mem_in = (in_mem_to_reg | in_mem_write) & ~mis_in;
   assign in_req    = (state_q == S_REQ);

   // Lane offset forced to the access size so the lane math never straddles
   // the bus word.
   always_comb begin
      off_al = alu_q[OFF_W-1:0];
      case (size_q)
         SZ_H:    off_al[0]   = 1'b0;
         SZ_W:    off_al[1:0] = 2'b00;
         SZ_D:    off_al      = '0;
         default: ;
      endcase
   end

   always_comb begin
      strb_c = '0;
      case (size_q)
         SZ_B:    strb_c = STRB_W'(1)    << off_al;
         SZ_H:    strb_c = STRB_W'(3)    << off_al;
         SZ_W:    strb_c = STRB_W'(4'hF) << off_al;
         default: strb_c = '1;
      endcase
   end

   // Store data replicated across every lane group of the access size, so the
   // strobes alone pick the destination bytes.
   always_comb begin
      wd_rep = '0;
      for (int i = 0; i < STRB_W; i++) begin
         case (size_q)
            SZ_B:    wd_rep[8*i +: 8] = wdata_q[7:0];
            SZ_H:    wd_rep[8*i +: 8] = wdata_q[8*(i%2) +: 8];
            SZ_W:    wd_rep[8*i +: 8] = wdata_q[8*(i%4) +: 8];
            default: wd_rep[8*i +: 8] = wdata_q[8*i +: 8];
         endcase
      end
   end

   // Load extraction: shift the addressed lanes down, mask to size, then fill
   // the upper bits with the sign bit unless zero-extending.
   always_comb begin
      shifted = dresp_rdata >> {off_al, 3'b000};
      mask    = '0;
      sgn     = 1'b0;
      case (size_q)
         SZ_B: begin
            mask[7:0] = '1;
            sgn       = shifted[7];
         end
         SZ_H: begin
            mask[15:0] = '1;
            sgn        = shifted[15];
         end
         SZ_W: begin
            mask[31:0] = '1;
            sgn        = shifted[31];
         end
         default: begin
            mask = '1;
            sgn  = shifted[DATA_W-1];
         end
      endcase
      ld_ext = (shifted & mask) | ((sgn & ~unsigned_q) ? ~mask : '0);
   end

   assign addr_full = ADDR_W'(alu_q);

   assign dreq_valid = in_req;
   assign dreq_addr  = in_req ? (addr_full & ~ADDR_W'(STRB_W - 1)) : '0;
   assign dreq_wen   = in_req & mem_write_q;
   assign dreq_strb  = in_req ? strb_c : '0;
   assign dreq_wdata = in_req ? wd_rep : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         alu_q        <= '0;
         wdata_q      <= '0;
         wreg_q       <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         size_q       <= SZ_B;
         unsigned_q   <= 1'b0;
         killed_q     <= 1'b0;
         rdata_q      <= '0;
         pcsrc_q      <= 1'b0;
      end else begin
         // Redirect is a single pulse tied to the capture edge, so a stalled
         // branch never re-fires it.
         pcsrc_q <= capture & in_branch & in_zero;

         if (capture) begin
            alu_q        <= in_alu_result;
            wdata_q      <= in_write_data;
            wreg_q       <= in_write_reg;
            reg_write_q  <= in_reg_write & ~mis_in;
            mem_to_reg_q <= in_mem_to_reg;
            mem_write_q  <= in_mem_write;
            size_q       <= size_in;
            unsigned_q   <= in_mem_unsigned;
            killed_q     <= 1'b0;
            rdata_q      <= '0;
            state_q      <= is_mem_in ? S_REQ : S_DONE;
         end else begin
            case (state_q)
               S_REQ: begin
                  if (flush) killed_q <= 1'b1;
                  if (dreq_ready) state_q <= S_WAIT;
               end
               S_WAIT: begin
                  if (dresp_valid) begin
                     state_q <= (killed_q | flush) ? S_IDLE : S_DONE;
                     if (mem_to_reg_q & ~killed_q & ~flush) rdata_q <= ld_ext;
                  end else if (flush) begin
                     killed_q <= 1'b1;
                  end
               end
               S_DONE: begin
                  if (flush | out_ready) state_q <= S_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        misalign_q <= 1'b0;
      else if (capture) misalign_q <= mis_in;
   end

   assign out_misalign = misalign_q;
`else
   assign out_misalign = 1'b0;
`endif

   assign pcsrc          = pcsrc_q;
   assign out_valid      = (state_q == S_DONE);
   assign out_alu_result = alu_q;
   assign out_read_data  = rdata_q;
   assign out_write_reg  = wreg_q;
   assign out_reg_write  = reg_write_q;
   assign out_mem_to_reg = mem_to_reg_q;

endmodule
